// File: rtl/apb_pkg.sv
// Shared APB widths, completer state encoding and address decode helpers.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  // Request captured in the setup phase and held for the whole access phase.
  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic                  err;
  } apb_req_t;

  // Word index of a byte address; the caller truncates to its index width.
  function automatic int unsigned addr_idx(input logic [APB_ADDR_W-1:0] addr,
                                           input int unsigned           num_regs);
    return int'(addr >> 2) & (num_regs - 1);
  endfunction

  // Out of range, unaligned, or a write aimed at a read-only register.
  function automatic logic decode_err(input logic [APB_ADDR_W-1:0] addr,
                                      input logic                  write,
                                      input logic                  ro,
                                      input int unsigned           num_regs);
    logic [APB_ADDR_W-1:0] limit;
    limit = APB_ADDR_W'(num_regs) << 2;
    return (addr >= limit) || (addr[1:0] != 2'b00) || (write && ro);
  endfunction

endpackage

// File: rtl/apb_slave_regbank.sv
// Register storage with one write port, an indexed read mux and RO mirroring.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int unsigned          NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
  parameter int                   IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic                           we,
  input  logic [IDX_W-1:0]               idx,
  input  logic [APB_DATA_W-1:0]          wdata,
  input  logic [NUM_REGS*APB_DATA_W-1:0] hw_status,
  output logic [APB_DATA_W-1:0]          rdata,
  output logic [NUM_REGS*APB_DATA_W-1:0] reg_q
);

  // Writable slots never look at their hw_status slice.
  logic unused_hw;
  assign unused_hw = ^hw_status;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_q[i*APB_DATA_W +: APB_DATA_W] = hw_status[i*APB_DATA_W +: APB_DATA_W];
    end else begin : g_rw
      logic [APB_DATA_W-1:0] q;
      // Storage word: cleared by reset, loaded on a committed write to this index.
      always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n)                  q <= '0;
        else if (we && idx == IDX_W'(i)) q <= wdata;
      end
      assign reg_q[i*APB_DATA_W +: APB_DATA_W] = q;
    end
  end

  assign rdata = reg_q[int'(idx)*APB_DATA_W +: APB_DATA_W];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer: setup/access FSM, wait states, error and protocol checks.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned         NUM_REGS    = 16,
  parameter int unsigned         WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic [APB_ADDR_W-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [APB_DATA_W-1:0]          pwdata,
  output logic [APB_DATA_W-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  input  logic [NUM_REGS*APB_DATA_W-1:0] hw_status,
  output logic [NUM_REGS*APB_DATA_W-1:0] reg_q,
  output logic                           prot_err
);

  localparam int IDX_W = $clog2(NUM_REGS);

  apb_slv_state_e        state, state_nxt;
  apb_req_t              lat;
  logic [3:0]            wait_cnt;
  logic [IDX_W-1:0]      idx_in, lat_idx;
  logic                  err_in, setup, complete, we, violation;
  logic [APB_DATA_W-1:0] rdata;

  assign idx_in   = IDX_W'(addr_idx(paddr, NUM_REGS));
  assign lat_idx  = IDX_W'(addr_idx(lat.addr, NUM_REGS));
  assign err_in   = decode_err(paddr, pwrite, RO_MASK[idx_in], NUM_REGS);
  assign setup    = (state == IDLE) && psel && !penable;
  assign pready   = (state == ACCESS) && (wait_cnt == '0);
  assign complete = pready && psel && penable;
  assign we       = complete && lat.write && !lat.err;
  assign pslverr  = pready && lat.err;
  assign prdata   = (pready && !lat.write && !lat.err) ? rdata : '0;

  // Protocol checks: access without setup, deselect mid-access, unstable request.
  always_comb begin
    violation = 1'b0;
    if (state == IDLE) violation = psel && penable;
    else if (!psel)    violation = 1'b1;
    else               violation = (paddr != lat.addr) || (pwrite != lat.write) ||
                                   (pwdata != lat.wdata);
  end

  // Next state: enter ACCESS on a setup phase, leave on completion or abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      ACCESS:  if (!psel || complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Capture the request at setup; count wait states down during ACCESS.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      lat      <= '0;
      wait_cnt <= '0;
    end else if (setup) begin
      lat      <= '{addr: paddr, write: pwrite, wdata: pwdata, err: err_in};
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if (state == ACCESS && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // One-cycle violation pulse, registered so it is glitch-free.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) prot_err <= 1'b0;
    else           prot_err <= violation;
  end

  apb_slave_regbank #(
    .NUM_REGS (NUM_REGS),
    .RO_MASK  (RO_MASK)
  ) u_bank (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .we        (we),
    .idx       (lat_idx),
    .wdata     (lat.wdata),
    .hw_status (hw_status),
    .rdata     (rdata),
    .reg_q     (reg_q)
  );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench: two completers (0 and 3 wait states, reg 2 RO on the second), vector
// table, hand sequences for protocol/reset corners, then random traffic.
module tb_apb_slave_regfile;

  localparam int N = 16;

  logic            pclk = 1'b0;
  logic            preset_n = 1'b0;
  logic [31:0]     paddr = '0, pwdata = '0;
  logic            psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [N*32-1:0] hw_status;
  logic [31:0]     prdata0, prdata3;
  logic            pready0, pready3, pslverr0, pslverr3, prot_err0, prot_err3;
  logic [N*32-1:0] reg_q0, reg_q3;

  always #5 pclk = ~pclk;

  apb_slave_regfile #(.NUM_REGS(N), .WAIT_CYCLES(0), .RO_MASK(16'h0000)) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .hw_status(hw_status), .reg_q(reg_q0), .prot_err(prot_err0));

  apb_slave_regfile #(.NUM_REGS(N), .WAIT_CYCLES(3), .RO_MASK(16'h0004)) u_dut3 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3), .hw_status(hw_status), .reg_q(reg_q3), .prot_err(prot_err3));

  int          n_cmp = 0, n_fail = 0, prot_cnt = 0;
  logic        tgt = 1'b0;
  logic [31:0] model [2][N];
  logic        cur_pready, cur_pslverr;
  logic [31:0] cur_prdata;

  assign cur_pready  = tgt ? pready3  : pready0;
  assign cur_pslverr = tgt ? pslverr3 : pslverr0;
  assign cur_prdata  = tgt ? prdata3  : prdata0;

  always @(negedge pclk) if (prot_err0 || prot_err3) prot_cnt++;

  typedef struct {
    bit          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference rules
  function automatic bit is_ro(input int d, input int i);
    return d == 1 && i == 2;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit exp_err(input int d, input bit wr, input logic [31:0] a);
    return (a >= 32'(N * 4)) || (a % 4 != 0) || (wr && is_ro(d, widx(a)));
  endfunction

  function automatic logic [31:0] exp_rd(input int d, input bit wr, input logic [31:0] a);
    if (wr || exp_err(d, wr, a)) return '0;
    if (is_ro(d, widx(a))) return hw_status[widx(a)*32 +: 32];
    return model[d][widx(a)];
  endfunction

  task automatic apply_model(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    if (wr && !exp_err(d, wr, a)) model[d][widx(a)] = wd;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) for (int i = 0; i < N; i++) model[d][i] = '0;
  endtask

  task automatic check_regs(input string name);
    for (int d = 0; d < 2; d++) for (int i = 0; i < N; i++) begin
      logic [31:0] act, exp;
      act = d == 1 ? reg_q3[i*32 +: 32] : reg_q0[i*32 +: 32];
      exp = is_ro(d, i) ? hw_status[i*32 +: 32] : model[d][i];
      check($sformatf("%s_d%0d_r%0d", name, d, i), act, exp);
    end
  endtask

  task automatic idle();
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  // Full transfer starting just after an edge; returns just after the completion edge.
  task automatic xfer(input bit d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int cyc);
    bit done;
    tgt = d; psel0 = !d; psel3 = d; penable = 1'b0;
    paddr = a; pwrite = wr; pwdata = wd;
    rd = '0; err = 1'b0; cyc = 1; done = 0;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc++;
      @(negedge pclk);
      if (cur_pready === 1'b1) begin
        rd = cur_prdata; err = cur_pslverr; done = 1;
      end
      @(posedge pclk); #1;
    end
    if (!done) check("xfer_done", 32'(done), 32'd1);
  endtask

  vec_t        vecs[13];
  logic [31:0] rd, a, wd, er;
  logic        err;
  int          cyc, base;
  bit          d, wr;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int w = 0; w < N; w++) hw_status[w*32 +: 32] = $urandom;
    hw_status[95:64] = 32'hA5A5A5A5;
    clear_model();

    vecs[0]  = '{0, 1, 32'h08, 32'hDEADBEEF, 32'h0,        0, 2};
    vecs[1]  = '{0, 0, 32'h08, 32'h0,        32'hDEADBEEF, 0, 2};
    vecs[2]  = '{0, 0, 32'h40, 32'h0,        32'h0,        1, 2};
    vecs[3]  = '{0, 1, 32'h06, 32'h55,       32'h0,        1, 2};
    vecs[4]  = '{0, 0, 32'h04, 32'h0,        32'h0,        0, 2};
    vecs[5]  = '{0, 0, 32'h3C, 32'h0,        32'h0,        0, 2};
    vecs[6]  = '{1, 0, 32'h00, 32'h0,        32'h0,        0, 5};
    vecs[7]  = '{1, 1, 32'h08, 32'h1234,     32'h0,        1, 5};
    vecs[8]  = '{1, 0, 32'h08, 32'h0,        32'hA5A5A5A5, 0, 5};
    vecs[9]  = '{1, 1, 32'h0C, 32'h77,       32'h0,        0, 5};
    vecs[10] = '{1, 0, 32'h0C, 32'h0,        32'h77,       0, 5};
    vecs[11] = '{1, 0, 32'h3D, 32'h0,        32'h0,        1, 5};
    vecs[12] = '{1, 1, 32'h80000000, 32'h1,  32'h0,        1, 5};

    // Reset state
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready",  32'({pready0, pready3}), 32'd0);
    check("rst_pslverr", 32'({pslverr0, pslverr3}), 32'd0);
    check("rst_prot",    32'({prot_err0, prot_err3}), 32'd0);
    check("rst_prdata0", prdata0, 32'd0);
    check("rst_prdata3", prdata3, 32'd0);
    check_regs("rst");
    @(posedge pclk); #1;
    preset_n = 1'b1;
    idle();

    // Vector table
    base = prot_cnt;
    foreach (vecs[i]) begin
      xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, cyc);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("vec%0d_cyc", i), 32'(cyc), 32'(vecs[i].cyc));
      apply_model(int'(vecs[i].d), vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      idle();
    end
    check("vec_reg2_dut0", reg_q0[95:64], 32'hDEADBEEF);
    check_regs("vec");

    // Back-to-back writes, no idle cycle between transfers
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4); wd = 32'h1000_0000 + 32'(i);
      xfer(0, 1, a, wd, rd, err, cyc);
      check($sformatf("b2b%0d_cyc", i), 32'(cyc), 32'd2);
      check($sformatf("b2b%0d_err", i), 32'(err), 32'd0);
      apply_model(0, 1, a, wd);
    end
    idle();
    check_regs("b2b");
    check("legal_no_prot", 32'(prot_cnt - base), 32'd0);

    // Access phase without a setup phase
    tgt = 0; psel0 = 1'b1; penable = 1'b1; paddr = 32'h0; pwrite = 1'b0;
    @(negedge pclk);
    check("noset_pready", 32'(pready0), 32'd0);
    @(posedge pclk); #1;
    psel0 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("noset_prot", 32'(prot_err0), 32'd1);
    check("noset_pready2", 32'(pready0), 32'd0);
    @(posedge pclk); #1;
    @(negedge pclk);
    check("noset_pulse", 32'(prot_err0), 32'd0);
    @(posedge pclk); #1;

    // Deselect in the middle of a waited access
    tgt = 1; psel3 = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h9999;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel3 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    @(negedge pclk);
    check("abort_prot", 32'(prot_err3), 32'd1);
    check("abort_pready", 32'(pready3), 32'd0);
    @(posedge pclk); #1;
    check_regs("abort");
    xfer(1, 0, 32'h10, 32'h9999, rd, err, cyc);
    check("abort_next_rd", rd, 32'd0);
    check("abort_next_cyc", 32'(cyc), 32'd5);
    check("abort_next_err", 32'(err), 32'd0);
    idle();

    // Request changes mid-access: latched values still win
    tgt = 1; psel3 = 1'b1; penable = 1'b0; paddr = 32'h14; pwrite = 1'b1; pwdata = 32'h1111;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    pwdata = 32'h2222;
    @(posedge pclk); #1;
    @(negedge pclk);
    check("chg_prot", 32'(prot_err3), 32'd1);
    pwdata = 32'h1111;
    for (int k = 0; k < 10 && pready3 !== 1'b1; k++) begin
      @(posedge pclk); #1; @(negedge pclk);
    end
    check("chg_pready", 32'(pready3), 32'd1);
    @(posedge pclk); #1;
    apply_model(1, 1, 32'h14, 32'h1111);
    idle();
    check_regs("chg");

    // Reset asserted during the access phase of a write
    tgt = 0; psel0 = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'hCAFE;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 preset_n = 1'b0;
    #1;
    check("rstmid_pready",  32'(pready0), 32'd0);
    check("rstmid_pslverr", 32'(pslverr0), 32'd0);
    check("rstmid_prdata",  prdata0, 32'd0);
    check("rstmid_prot",    32'(prot_err0), 32'd0);
    clear_model();
    check_regs("rstmid");
    @(posedge pclk); #1;
    psel0 = 1'b0; penable = 1'b0; preset_n = 1'b1;
    idle();
    xfer(0, 0, 32'h0C, 32'h0, rd, err, cyc);
    check("rstmid_read", rd, 32'd0);
    idle();
    check_regs("rstpost");

    // Random traffic against the reference model
    base = prot_cnt;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        for (int w = 0; w < N; w++) hw_status[w*32 +: 32] = $urandom;
      end
      d  = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        default: a = 32'($urandom_range(0, 17)) * 4;
      endcase
      er = exp_rd(int'(d), wr, a);
      xfer(d, wr, a, wd, rd, err, cyc);
      check($sformatf("rnd%0d_rdata", t), rd, er);
      check($sformatf("rnd%0d_err", t), 32'(err), 32'(exp_err(int'(d), wr, a)));
      check($sformatf("rnd%0d_cyc", t), 32'(cyc), d ? 32'd5 : 32'd2);
      apply_model(int'(d), wr, a, wd);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
    check_regs("rnd");
    check("rnd_no_prot", 32'(prot_cnt - base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
